// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit multiplexed hex display:
// state encoding, active-low digit-enable patterns and default timing.
package display_pkg;

  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } state_e;

  localparam logic [1:0] AN_D0  = 2'b10;
  localparam logic [1:0] AN_D1  = 2'b01;
  localparam logic [1:0] AN_OFF = 2'b11;

  localparam int DEF_CNT_W     = 16;
  localparam int DEF_BLANK_CYC = 64;

  function automatic logic is_show(input state_e s);
    return (s == SHOW0) || (s == SHOW1);
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Cycle counter for the current display phase: synchronous clear on a
// phase change and a terminal-count flag against a caller-supplied limit.
module phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == term);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_mux.sv
// Two-digit time-multiplexed display driver: alternates digit 0 and digit 1
// with a blanking dead-time between them; every output is registered.
module display_mux
  import display_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [3:0] digit_val,
  output logic [1:0] an,
  output logic       blank
);

  if (CNT_W < 2 || BLANK_CYC < 1 || longint'(BLANK_CYC) > (longint'(1) << CNT_W)) begin : g_bad_params
    $error("display_mux: illegal CNT_W=%0d / BLANK_CYC=%0d", CNT_W, BLANK_CYC);
  end

  localparam logic [CNT_W-1:0] SHOW_TERM  = '1;
  localparam logic [CNT_W-1:0] BLANK_TERM = CNT_W'(BLANK_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] term;
  logic             tc;
  logic [1:0]       an_q, an_d;
  logic             blank_q, blank_d;
  logic [3:0]       digit_val_q, digit_val_d;

  assign term = is_show(state_q) ? SHOW_TERM : BLANK_TERM;

  // Every terminal count is a phase change, so it doubles as the clear.
  phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tc),
    .term    (term),
    .tc      (tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= BLANK1;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tc) begin
      case (state_q)
        SHOW0:   state_d = BLANK0;
        BLANK0:  state_d = SHOW1;
        SHOW1:   state_d = BLANK1;
        BLANK1:  state_d = SHOW0;
        default: state_d = BLANK1;
      endcase
    end
  end

  // Outputs derive from the next state so they change on the same edge.
  always_comb begin
    an_d        = AN_OFF;
    blank_d     = 1'b1;
    digit_val_d = digit_val_q;
    case (state_d)
      SHOW0: begin
        an_d    = AN_D0;
        blank_d = 1'b0;
        if (state_q != SHOW0) digit_val_d = s0;
      end
      SHOW1: begin
        an_d    = AN_D1;
        blank_d = 1'b0;
        if (state_q != SHOW1) digit_val_d = s1;
      end
      default: begin
        an_d    = AN_OFF;
        blank_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q        <= AN_OFF;
      blank_q     <= 1'b1;
      digit_val_q <= 4'h0;
    end else begin
      an_q        <= an_d;
      blank_q     <= blank_d;
      digit_val_q <= digit_val_d;
    end
  end

  assign an        = an_q;
  assign blank     = blank_q;
  assign digit_val = digit_val_q;

endmodule

// File: tb/tb_display_mux.sv
// Directed bench for display_mux: main instance CNT_W=4/BLANK_CYC=2
// (period 36) and a small instance CNT_W=2/BLANK_CYC=1 (period 10).
module tb_display_mux;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] s0 = 4'h3;
  logic [3:0] s1 = 4'hA;
  logic [3:0] digit_val, b_digit_val;
  logic [1:0] an, b_an;
  logic       blank, b_blank;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  display_mux #(.CNT_W(4), .BLANK_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n), .s0(s0), .s1(s1),
    .digit_val(digit_val), .an(an), .blank(blank)
  );

  display_mux #(.CNT_W(2), .BLANK_CYC(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .s0(s0), .s1(s1),
    .digit_val(b_digit_val), .an(b_an), .blank(b_blank)
  );

  // Expected an for edge k after release; first SHOW0 entry at edge off.
  function automatic logic [1:0] exp_an(input int k, input int off, input int sl, input int bl);
    int q;
    if (k < off) return 2'b11;
    q = (k - off) % (2 * (sl + bl));
    if (q < sl)           return 2'b10;
    if (q < sl + bl)      return 2'b11;
    if (q < 2 * sl + bl)  return 2'b01;
    return 2'b11;
  endfunction

  // Expected digit_val; s0 switches from old0 to new0 after edge chg_k.
  function automatic logic [3:0] exp_dv(input int k, input int off, input int sl, input int bl,
                                        input int chg_k, input logic [3:0] old0,
                                        input logic [3:0] new0, input logic [3:0] v1);
    int q;
    if (k < off) return 4'h0;
    q = (k - off) % (2 * (sl + bl));
    if (q < sl + bl) return ((k - q) <= chg_k) ? old0 : new0;
    return v1;
  endfunction

  task automatic restart();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({an, blank, digit_val} !== {2'b11, 1'b1, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_a: an=%b blank=%b dv=%h want an=11 blank=1 dv=0", an, blank, digit_val);
    end
    n_checks++;
    if ({b_an, b_blank, b_digit_val} !== {2'b11, 1'b1, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_b: an=%b blank=%b dv=%h want an=11 blank=1 dv=0", b_an, b_blank, b_digit_val);
    end
  endtask

  task automatic test_sequence();
    logic [1:0] ea;
    logic [3:0] ed;
    s0 = 4'h3; s1 = 4'hA;
    restart();
    for (int k = 1; k <= 76; k++) begin
      @(posedge clk); #1;
      ea = exp_an(k, 2, 16, 2);
      ed = exp_dv(k, 2, 16, 2, 1000, 4'h3, 4'h3, 4'hA);
      n_checks++;
      if ({an, blank, digit_val} !== {ea, (ea == 2'b11), ed}) begin
        n_fail++;
        $display("FAIL seq_a k=%0d: an=%b blank=%b dv=%h want an=%b blank=%b dv=%h",
                 k, an, blank, digit_val, ea, (ea == 2'b11), ed);
      end
      ea = exp_an(k, 1, 4, 1);
      ed = exp_dv(k, 1, 4, 1, 1000, 4'h3, 4'h3, 4'hA);
      n_checks++;
      if ({b_an, b_blank, b_digit_val} !== {ea, (ea == 2'b11), ed}) begin
        n_fail++;
        $display("FAIL seq_b k=%0d: an=%b blank=%b dv=%h want an=%b blank=%b dv=%h",
                 k, b_an, b_blank, b_digit_val, ea, (ea == 2'b11), ed);
      end
    end
  endtask

  task automatic test_s0_change();
    logic [3:0] ed;
    s0 = 4'h3; s1 = 4'hA;
    restart();
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      ed = exp_dv(k, 2, 16, 2, 9, 4'h3, 4'h7, 4'hA);
      n_checks++;
      if (digit_val !== ed) begin
        n_fail++;
        $display("FAIL s0_change_a k=%0d: dv=%h want %h", k, digit_val, ed);
      end
      ed = exp_dv(k, 1, 4, 1, 9, 4'h3, 4'h7, 4'hA);
      n_checks++;
      if (b_digit_val !== ed) begin
        n_fail++;
        $display("FAIL s0_change_b k=%0d: dv=%h want %h", k, b_digit_val, ed);
      end
      if (k == 9) s0 = 4'h7;
    end
  endtask

  task automatic test_reset_mid();
    s0 = 4'h5; s1 = 4'hC;
    restart();
    repeat (24) @(posedge clk);
    #1;
    n_checks++;
    if ({an, digit_val} !== {2'b01, 4'hC}) begin
      n_fail++;
      $display("FAIL mid_pre: an=%b dv=%h want an=01 dv=c", an, digit_val);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({an, blank, digit_val} !== {2'b11, 1'b1, 4'h0}) begin
      n_fail++;
      $display("FAIL mid_async: an=%b blank=%b dv=%h want an=11 blank=1 dv=0", an, blank, digit_val);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    s0 = 4'h9;
    @(posedge clk); #1;
    n_checks++;
    if ({an, blank, digit_val} !== {2'b11, 1'b1, 4'h0}) begin
      n_fail++;
      $display("FAIL mid_blank: an=%b blank=%b dv=%h want an=11 blank=1 dv=0", an, blank, digit_val);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({an, blank, digit_val} !== {2'b10, 1'b0, 4'h9}) begin
      n_fail++;
      $display("FAIL mid_show0: an=%b blank=%b dv=%h want an=10 blank=0 dv=9", an, blank, digit_val);
    end
  endtask

  task automatic test_random();
    logic [3:0] p0, p1, cur_dv;
    logic [1:0] prev_an, last_show;
    int blank_run, show_run;
    bit started;
    restart();
    prev_an = 2'b11; last_show = 2'b01; cur_dv = 4'h0;
    blank_run = 0; show_run = 0; started = 0;
    for (int c = 0; c < 10000; c++) begin
      p0 = s0; p1 = s1;
      @(posedge clk); #1;
      if (an == 2'b10 && prev_an != 2'b10) cur_dv = p0;
      if (an == 2'b01 && prev_an != 2'b01) cur_dv = p1;
      n_checks++;
      if (an === 2'b00 || blank !== (an == 2'b11) || digit_val !== cur_dv) begin
        n_fail++;
        $display("FAIL rand c=%0d: an=%b blank=%b dv=%h want dv=%h", c, an, blank, digit_val, cur_dv);
      end
      if (an == 2'b11) begin
        if (prev_an != 2'b11) begin
          n_checks++;
          if (show_run != 16) begin
            n_fail++;
            $display("FAIL rand_show_len c=%0d: got %0d want 16", c, show_run);
          end
        end
        blank_run++;
      end else begin
        if (prev_an == 2'b11) begin
          n_checks++;
          if ((started && blank_run != 2) || an == last_show) begin
            n_fail++;
            $display("FAIL rand_blank c=%0d: blank_run=%0d an=%b last=%b want 2, alternating",
                     c, blank_run, an, last_show);
          end
          started = 1; last_show = an; blank_run = 0; show_run = 0;
        end
        show_run++;
      end
      prev_an = an;
      s0 = 4'($urandom_range(15));
      s1 = 4'($urandom_range(15));
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_s0_change();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_mux.md
DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  CNT_W  16  log2 of SHOW-phase length in clk cycles
  BLANK_CYC  64  BLANK-phase length in clk cycles
REQ-002 Ports (name  direction  width  meaning), one per line:
  clk  input  1  system clock, all state on rising edge
  reset_n  input  1  asynchronous active-low reset
  s0  input  4  hex value for digit 0
  s1  input  4  hex value for digit 1
  digit_val  output  4  selected nibble, feeds downstream hex-to-7-seg decoder
  an  output  2  active-low digit enables; an[0] = digit 0, an[1] = digit 1
  blank  output  1  high during dead-time; segments must be off
REQ-003 Clocking and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-004 Parameter legality: CNT_W >= 2; 1 <= BLANK_CYC <= 2^CNT_W; elaboration SHALL fail otherwise.

Function
REQ-005 States: SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 -> SHOW0, no other transitions.
REQ-006 A phase counter SHALL count clk cycles in the current state and clear to 0 on every state transition.
REQ-007 SHOW0/SHOW1 transition when counter == 2^CNT_W-1, so each lasts exactly 2^CNT_W cycles.
REQ-008 BLANK0/BLANK1 transition when counter == BLANK_CYC-1, so each lasts exactly BLANK_CYC cycles.
REQ-009 Full refresh period = 2*(2^CNT_W + BLANK_CYC) cycles; no drift, counter wraps only via REQ-006.
REQ-010 All outputs registered and updated on the same edge as the state register (zero-cycle lag to state).
REQ-011 SHOW0: an=2'b10, blank=0, digit_val = s0 sampled on the edge entering SHOW0.
REQ-012 SHOW1: an=2'b01, blank=0, digit_val = s1 sampled on the edge entering SHOW1.
REQ-013 BLANK0/BLANK1: an=2'b11, blank=1, digit_val holds its previous value.
REQ-014 s0/s1 changes during a SHOW phase SHALL NOT affect digit_val until the next entry to that digit's SHOW state.
REQ-015 an SHALL never be 2'b00; an SHALL never go directly from 2'b10 to 2'b01 or vice versa without >= BLANK_CYC cycles of 2'b11.
REQ-016 Arithmetic: counter unsigned, width CNT_W; no overflow reachable under REQ-004.

Reset
REQ-017 reset_n low SHALL immediately (asynchronously) force: state=BLANK1, counter=0, an=2'b11, blank=1, digit_val=4'h0.
REQ-018 After reset_n rises, the block SHALL spend exactly BLANK_CYC cycles in BLANK1, then enter SHOW0 sampling s0.
REQ-019 Reset asserted mid-phase SHALL abandon the phase with no partial output; sequence restarts per REQ-018.

Structure
REQ-020 Shared package display_pkg SHALL hold the state enum (SHOW0, BLANK0, SHOW1, BLANK1), the an encodings (AN_D0=2'b10, AN_D1=2'b01, AN_OFF=2'b11), and default CNT_W/BLANK_CYC.
REQ-021 One sub-module is natural: phase_counter (counter with sync clear and terminal-count compare); FSM and output registers stay in display_mux.
REQ-022 digit_val connects directly to the existing hex decoder at top level; display_mux SHALL NOT decode segments.

Verification (CNT_W=4, BLANK_CYC=2 unless stated; period 36 cycles)
REQ-023 Reset release, s0=4'h3, s1=4'hA -> an=11/blank=1 for 2 cycles, an=10/digit_val=3 for 16, an=11 for 2, an=01/digit_val=A for 16, repeat.
REQ-024 Change s0 4'h3->4'h7 at cycle 8 of SHOW0 -> digit_val stays 3 through that SHOW0; shows 7 on next SHOW0 entry.
REQ-025 Assert reset_n low at cycle 5 of SHOW1 -> outputs go to an=11, blank=1, digit_val=0 before next edge; REQ-018 sequence resumes on release.
REQ-026 Run 10000 cycles with random s0/s1 -> assertion: an != 00, every an 10<->01 change separated by exactly 2 cycles of an=11, blank == (an==11).
REQ-027 BLANK_CYC=1, CNT_W=2 -> period 10 cycles, single-cycle blank phases verified; BLANK_CYC=5, CNT_W=2 -> elaboration error.
